// File: rtl/seg7_signed_scan.sv
// Multiplexed seven-segment driver for signed samples: sequential shift-add-3 binary-to-BCD
// conversion behind a load/busy handshake, sign on the top digit. Define SEG7_LZB_EN for leading-zero blanking.
`timescale 1ns/1ps

module seg7_signed_scan #(
    parameter int DIGITS         = 4,
    parameter int IN_W           = 9,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [IN_W-1:0]   value,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [0:6]        seg,
    output logic [DIGITS-1:0] digit
);

    localparam int MAG_D = DIGITS - 1;
    localparam int BCD_W = 4 * MAG_D;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SEL_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1'b1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(DIGITS - 1);
    localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1'b1);
    localparam logic [IN_W-1:0]   IN_ONE    = IN_W'(1'b1);
    localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1'b1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic             busy_r;
    logic [IN_W-1:0]  mag_r, mag_in_s;
    logic             sign_r;
    logic [BCD_W-1:0] bcd_r, bcd_adj_s, bcd_shift_s;
    logic             shift_out_s;
    logic             ovf_r;
    logic [CNT_W-1:0] iter_r;
    logic [BCD_W-1:0] disp_bcd_r;
    logic             disp_sign_r;
    logic             overflow_r;
    logic [TMR_W-1:0] timer_r;
    logic [SEL_W-1:0] sel_r;
    logic [3:0]       cur_nib_s;
    logic [0:6]       seg_s;
    logic [DIGITS-1:0] digit_s;

    function automatic logic [0:6] seg_of_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_of_digit = 7'b0000001;
            4'd1:    seg_of_digit = 7'b1001111;
            4'd2:    seg_of_digit = 7'b0010010;
            4'd3:    seg_of_digit = 7'b0000110;
            4'd4:    seg_of_digit = 7'b1001100;
            4'd5:    seg_of_digit = 7'b0100100;
            4'd6:    seg_of_digit = 7'b0100000;
            4'd7:    seg_of_digit = 7'b0001111;
            4'd8:    seg_of_digit = 7'b0000000;
            4'd9:    seg_of_digit = 7'b0000100;
            default: seg_of_digit = 7'b1111111;
        endcase
    endfunction

    // Magnitude of the incoming sample; the most negative input maps exactly onto IN_W bits.
    always_comb begin
        if (value[IN_W-1]) begin
            mag_in_s = ~value + IN_ONE;
        end else begin
            mag_in_s = value;
        end
    end

    // One shift-add-3 step: correct every nibble >= 5, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < MAG_D; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        bcd_shift_s = {bcd_adj_s[BCD_W-2:0], mag_r[IN_W-1]};
        shift_out_s = bcd_adj_s[BCD_W-1];
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_next_s = CONVERT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONVERT: begin
                if (iter_r == LAST_ITER) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Conversion FSM state, working registers and display registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            mag_r       <= '0;
            sign_r      <= 1'b0;
            bcd_r       <= '0;
            ovf_r       <= 1'b0;
            iter_r      <= '0;
            disp_bcd_r  <= '0;
            disp_sign_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (load) begin
                        sign_r <= value[IN_W-1];
                        mag_r  <= mag_in_s;
                        bcd_r  <= '0;
                        ovf_r  <= 1'b0;
                        iter_r <= '0;
                    end
                end
                CONVERT: begin
                    bcd_r  <= bcd_shift_s;
                    mag_r  <= {mag_r[IN_W-2:0], 1'b0};
                    ovf_r  <= ovf_r | shift_out_s;
                    iter_r <= iter_r + CNT_ONE;
                end
                DONE: begin
                    disp_bcd_r  <= bcd_r;
                    disp_sign_r <= sign_r;
                    overflow_r  <= ovf_r;
                end
                default: begin
                    iter_r <= '0;
                end
            endcase
        end
    end

    // Refresh timer and digit scan pointer; free-running, independent of conversion.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
            sel_r   <= '0;
        end else if (timer_r == TMR_LAST) begin
            timer_r <= '0;
            sel_r   <= (sel_r == SEL_LAST) ? '0 : sel_r + SEL_ONE;
        end else begin
            timer_r <= timer_r + TMR_ONE;
        end
    end

`ifdef SEG7_LZB_EN
    logic upper_nz_s;

    // Any non-zero magnitude digit at or above the lit position keeps it visible.
    always_comb begin
        upper_nz_s = 1'b0;
        for (int i = 0; i < MAG_D; i++) begin
            if ((SEL_W'(i) >= sel_r) && (disp_bcd_r[4*i +: 4] != 4'd0)) begin
                upper_nz_s = 1'b1;
            end else begin
                upper_nz_s = upper_nz_s;
            end
        end
    end
`endif

    // Anode select and segment pattern for the currently lit digit.
    always_comb begin
        digit_s   = ~(DIG_ONE << sel_r);
        cur_nib_s = 4'd0;
        for (int i = 0; i < MAG_D; i++) begin
            if (SEL_W'(i) == sel_r) begin
                cur_nib_s = disp_bcd_r[4*i +: 4];
            end else begin
                cur_nib_s = cur_nib_s;
            end
        end
        if (sel_r == SEL_LAST) begin
            seg_s = disp_sign_r ? 7'b1111110 : 7'b1111111;
        end else if (overflow_r) begin
            seg_s = 7'b0110000;
`ifdef SEG7_LZB_EN
        end else if ((sel_r != '0) && !upper_nz_s) begin
            seg_s = 7'b1111111;
`endif
        end else begin
            seg_s = seg_of_digit(cur_nib_s);
        end
    end

    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign seg      = seg_s;
    assign digit    = digit_s;

endmodule

// File: tb/tb_seg7_signed_scan.sv
// Randomized self-checking bench for seg7_signed_scan: a 4-digit and a 3-digit instance share stimulus
// and are compared against a decimal-arithmetic model of the display.
`timescale 1ns/1ps

module tb_seg7_signed_scan;

    localparam int IN_W = 9;
    localparam int RC   = 4;
    localparam int DA   = 4;
    localparam int DB   = 3;

    logic            clk_100MHz = 1'b0;
    logic            reset      = 1'b1;
    logic            load       = 1'b0;
    logic [IN_W-1:0] value      = '0;
    logic            busy_a, ovf_a, busy_b, ovf_b;
    logic [0:6]      seg_a, seg_b;
    logic [DA-1:0]   digit_a;
    logic [DB-1:0]   digit_b;

    int checks  = 0;
    int errors  = 0;
    int edges   = 0;
    int disp_val = 0;
    bit scan_en = 1'b0;

    seg7_signed_scan #(.DIGITS(DA), .IN_W(IN_W), .REFRESH_CYCLES(RC)) u_dut_a (
        .clk_100MHz(clk_100MHz), .reset(reset), .value(value), .load(load),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .digit(digit_a));

    seg7_signed_scan #(.DIGITS(DB), .IN_W(IN_W), .REFRESH_CYCLES(RC)) u_dut_b (
        .clk_100MHz(clk_100MHz), .reset(reset), .value(value), .load(load),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .digit(digit_b));

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_int(input logic [IN_W-1:0] x);
        if (x[IN_W-1]) return int'(x) - (1 << IN_W);
        else return int'(x);
    endfunction

    function automatic bit exp_ovf(input int nd, input int v);
        int mag = (v < 0) ? -v : v;
        return mag > pow10(nd - 1) - 1;
    endfunction

    function automatic logic [6:0] exp_seg(input int nd, input int sel, input int v);
        int mag = (v < 0) ? -v : v;
        if (sel == nd - 1) return (v < 0) ? 7'b1111110 : 7'b1111111;
        if (exp_ovf(nd, v)) return 7'b0110000;
`ifdef SEG7_LZB_EN
        if (sel > 0 && mag < pow10(sel)) return 7'b1111111;
`endif
        case ((mag / pow10(sel)) % 10)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic logic [31:0] exp_digit(input int nd, input int sel);
        return (~(32'd1 << sel)) & ((32'd1 << nd) - 32'd1);
    endfunction

    // Edge count since reset release: the scan position follows from it directly.
    always @(posedge clk_100MHz) begin
        if (reset) edges <= 0;
        else edges <= edges + 1;
    end

    // Continuous scan check of both instances against the model display value.
    always @(negedge clk_100MHz) begin : scan_chk
        int sa, sb;
        #1;
        if (scan_en) begin
            sa = (edges / RC) % DA;
            sb = (edges / RC) % DB;
            check_val("digit_a", {28'd0, digit_a}, exp_digit(DA, sa));
            check_val("digit_b", {29'd0, digit_b}, exp_digit(DB, sb));
            check_val("seg_a", {25'd0, seg_a}, {25'd0, exp_seg(DA, sa, disp_val)});
            check_val("seg_b", {25'd0, seg_b}, {25'd0, exp_seg(DB, sb, disp_val)});
        end
    end

    task automatic check_reset_state(input string tag);
        check_val({tag, "_digit_a"}, {28'd0, digit_a}, 32'h0000000E);
        check_val({tag, "_digit_b"}, {29'd0, digit_b}, 32'h00000006);
        check_val({tag, "_seg_a"}, {25'd0, seg_a}, 32'h00000001);
        check_val({tag, "_seg_b"}, {25'd0, seg_b}, 32'h00000001);
        check_val({tag, "_busy"}, {30'd0, busy_a, busy_b}, 32'd0);
        check_val({tag, "_ovf"}, {30'd0, ovf_a, ovf_b}, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        reset    = 1'b0;
        disp_val = 0;
        scan_en  = 1'b1;
    endtask

    task automatic do_load(input logic [IN_W-1:0] v, input bit inject);
        int n = 0;
        @(negedge clk_100MHz);
        value = v;
        load  = 1'b1;
        @(posedge clk_100MHz);
        #1;
        load = 1'b0;
        while (busy_a && n < 40) begin
            if (inject && n == 3) begin
                value = ~v;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk_100MHz);
            #1;
            n++;
        end
        load     = 1'b0;
        disp_val = to_int(v);
        check_val("busy_cycles", n, IN_W + 1);
        check_val("busy_b_done", {31'd0, busy_b}, 32'd0);
        check_val("ovf_a", {31'd0, ovf_a}, {31'd0, exp_ovf(DA, disp_val)});
        check_val("ovf_b", {31'd0, ovf_b}, {31'd0, exp_ovf(DB, disp_val)});
    endtask

    initial begin
        #1;
        check_reset_state("por");
        release_reset();
        repeat (6) @(posedge clk_100MHz);

        // Reset in the middle of a refresh period.
        @(negedge clk_100MHz);
        scan_en = 1'b0;
        reset   = 1'b1;
        #1;
        check_reset_state("mid_rst");
        release_reset();

        do_load(9'h07B, 1'b0);
        repeat (24) @(posedge clk_100MHz);
        do_load(9'h100, 1'b0);
        repeat (16) @(posedge clk_100MHz);
        do_load(9'd150, 1'b0);
        repeat (16) @(posedge clk_100MHz);
        do_load(9'd5, 1'b0);
        repeat (16) @(posedge clk_100MHz);
        do_load(9'd42, 1'b1);
        repeat (16) @(posedge clk_100MHz);

        // Abort a conversion of -1 four cycles into CONVERT.
        @(negedge clk_100MHz);
        value = 9'h1FF;
        load  = 1'b1;
        @(posedge clk_100MHz);
        #1;
        load = 1'b0;
        repeat (4) @(posedge clk_100MHz);
        #2;
        scan_en = 1'b0;
        reset   = 1'b1;
        #1;
        check_reset_state("abort");
        release_reset();
        do_load(9'h1FF, 1'b0);
        repeat (16) @(posedge clk_100MHz);

        do_load(9'd0, 1'b0);
        do_load(9'd255, 1'b0);
        do_load(9'd99, 1'b0);
        do_load(9'd100, 1'b0);
        repeat (25) begin
            do_load(IN_W'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(2, 20)) @(posedge clk_100MHz);
        end
        repeat (16) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        scan_en = 1'b0;
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
